// File: rtl/muldiv_types.sv
// Types and constants for the iterative RV32M multiply/divide unit.
package muldiv_types;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } m_op_t;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  function automatic logic op_is_rem(input m_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_rs1_signed(input m_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_rs2_signed(input m_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mulmux_pkg.sv
// Writeback mux select shared between the ALU and the multi-cycle M-extension unit.
package mulmux_pkg;

  typedef enum logic {
    TRUE_ALU_OUT = 1'b0,
    MUL_OUT      = 1'b1
  } mulmux_sel_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX-stage controller and the mul/div unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  import mulmux_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall;
  mulmux_sel_t     mulmux_sel;

  modport master (
    output start, funct3, rs1, rs2, flush,
    input  busy, done, result, stall, mulmux_sel
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush,
    output busy, done, result, stall, mulmux_sel
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// Multiply: {hi,lo} is the accumulator, lo initially the multiplier. Divide: hi is the remainder, lo the dividend/quotient.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN:0]   i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN:0]   o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_ge;

  always_comb begin
    w_sum   = i_hi + {1'b0, ({XLEN{i_lo[0]}} & i_opnd)};
    w_shift = {i_hi[XLEN-1:0], i_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, i_opnd};
    w_ge    = (w_shift >= {1'b0, i_opnd});
    o_hi    = {1'b0, w_sum[XLEN:1]};
    o_lo    = {w_sum[0], i_lo[XLEN-1:1]};
    if (i_div) begin
      o_hi = w_ge ? w_diff : w_shift;
      o_lo = {i_lo[XLEN-2:0], w_ge};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: sequences a shift-add multiplier and a restoring divider,
// stalling the pipeline while it iterates and steering the writeback mux on completion.
module muldiv_unit
  import muldiv_types::*;
  import mulmux_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned     CNT_W        = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(XLEN - UNROLL);
  localparam logic [CNT_W-1:0] CNT_STEP    = CNT_W'(UNROLL);
  localparam logic [XLEN-1:0] OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   r_state;
  m_op_t           r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN:0]   r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;
  logic            r_neg;
  logic [XLEN-1:0] r_result;
  logic            r_done;
  logic            r_busy;
  mulmux_sel_t     r_sel;

  // Request decode: magnitudes, result sign and the divide short-cuts.
  m_op_t           w_op;
  logic            w_is_div;
  logic            w_is_rem;
  logic            w_sa;
  logic            w_sb;
  logic            w_neg;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_fast_res;

  always_comb begin
    w_op       = m_op_t'(bus.funct3);
    w_is_div   = bus.funct3[2];
    w_is_rem   = op_is_rem(w_op);
    w_sa       = op_rs1_signed(w_op) & bus.rs1[XLEN-1];
    w_sb       = op_rs2_signed(w_op) & bus.rs2[XLEN-1];
    w_neg      = w_is_rem ? w_sa : (w_sa ^ w_sb);
    w_mag_a    = w_sa ? -bus.rs1 : bus.rs1;
    w_mag_b    = w_sb ? -bus.rs2 : bus.rs2;
    w_div0     = w_is_div && (bus.rs2 == '0);
    w_ovf      = w_is_div && !bus.funct3[0] && (bus.rs1 == OVF_DIVIDEND) && (bus.rs2 == '1);
    w_fast_res = w_div0 ? (w_is_rem ? bus.rs1 : '1) : (w_is_rem ? '0 : OVF_DIVIDEND);
  end

  logic w_div_mode;
  assign w_div_mode = (r_state == S_DIV);

  // UNROLL chained steps per cycle; each stage has its own nets to keep the chain acyclic.
  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    logic [XLEN:0]   w_hi_in;
    logic [XLEN-1:0] w_lo_in;
    logic [XLEN:0]   w_hi_out;
    logic [XLEN-1:0] w_lo_out;

    if (g == 0) begin : g_first
      assign w_hi_in = r_hi;
      assign w_lo_in = r_lo;
    end else begin : g_next
      assign w_hi_in = g_step[g-1].w_hi_out;
      assign w_lo_in = g_step[g-1].w_lo_out;
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
      .i_div  (w_div_mode),
      .i_hi   (w_hi_in),
      .i_lo   (w_lo_in),
      .i_opnd (r_opnd),
      .o_hi   (w_hi_out),
      .o_lo   (w_lo_out)
    );
  end

  logic [XLEN:0]     w_hi_nxt;
  logic [XLEN-1:0]   w_lo_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN-1:0]   w_div_mag;
  logic [XLEN-1:0]   w_div_res;
  logic              w_unused;

  // Sign is applied only to the final magnitude, on the way into the result register.
  always_comb begin
    w_hi_nxt  = g_step[UNROLL-1].w_hi_out;
    w_lo_nxt  = g_step[UNROLL-1].w_lo_out;
    w_prod    = {w_hi_nxt[XLEN-1:0], w_lo_nxt};
    w_prod_s  = r_neg ? -w_prod : w_prod;
    w_mul_res = (r_op == OP_MUL) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
    w_div_mag = op_is_rem(r_op) ? w_hi_nxt[XLEN-1:0] : w_lo_nxt;
    w_div_res = r_neg ? -w_div_mag : w_div_mag;
    w_unused  = w_hi_nxt[XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_MUL;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_sel    <= TRUE_ALU_OUT;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_sel   <= TRUE_ALU_OUT;
    end else begin
      r_done <= 1'b0;
      r_sel  <= TRUE_ALU_OUT;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_op   <= w_op;
            r_neg  <= w_neg;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_busy <= 1'b1;
            if (w_div0 || w_ovf) begin
              r_state  <= S_DONE;
              r_result <= w_fast_res;
              r_done   <= 1'b1;
              r_sel    <= MUL_OUT;
            end else if (w_is_div) begin
              r_state <= S_DIV;
              r_lo    <= w_mag_a;
              r_opnd  <= w_mag_b;
            end else begin
              r_state <= S_MUL;
              r_lo    <= w_mag_b;
              r_opnd  <= w_mag_a;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_MUL, S_DIV: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + CNT_STEP;
          if (r_cnt == LAST_CNT) begin
            r_state  <= S_DONE;
            r_cnt    <= '0;
            r_result <= (r_state == S_MUL) ? w_mul_res : w_div_res;
            r_done   <= 1'b1;
            r_sel    <= MUL_OUT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall is combinational so the issuing cycle is already held.
  assign bus.stall      = ~rst & (((r_state == S_IDLE) & bus.start) |
                                  (r_state == S_MUL) | (r_state == S_DIV));
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.result     = r_result;
  assign bus.mulmux_sel = r_sel;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level behavioural model plus directed and random ops.
module tb_muldiv_unit;
  import muldiv_types::*;
  import mulmux_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int          ITER = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();
  muldiv_unit #(.XLEN(XLEN), .UNROLL(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // RISC-V M semantics computed with wide plain arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] as_;
    logic signed [63:0] bs_;
    logic [63:0] p;
    as_ = {{32{a[31]}}, a};
    bs_ = {{32{b[31]}}, b};
    case (f)
      3'd0: begin p = as_ * bs_; return p[31:0]; end
      3'd1: begin p = as_ * bs_; return p[63:32]; end
      3'd2: begin p = as_ * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = as_ / bs_; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        p = as_ % bs_; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'd0) || (!f[0] && a == DIV_OVF_DIVIDEND && b == 32'hFFFF_FFFF));
  endfunction

  // Cycle-level model: an accepted op completes ITER+1 cycles later, or next cycle on a short-cut.
  logic        m_pending  = 1'b0;
  logic        m_done_now = 1'b0;
  int          m_left     = 0;
  logic [31:0] m_res      = '0;
  logic [31:0] m_next     = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending  <= 1'b0;
      m_done_now <= 1'b0;
      m_left     <= 0;
      m_res      <= '0;
      m_next     <= '0;
    end else if (bus.flush) begin
      m_pending  <= 1'b0;
      m_done_now <= 1'b0;
    end else if (m_pending) begin
      m_done_now <= (m_left == 1);
      m_left     <= m_left - 1;
      if (m_left == 1) begin
        m_pending <= 1'b0;
        m_res     <= m_next;
      end
    end else begin
      m_done_now <= 1'b0;
      if (bus.start) begin
        if (is_fast(bus.funct3, bus.rs1, bus.rs2)) begin
          m_done_now <= 1'b1;
          m_res      <= ref_model(bus.funct3, bus.rs1, bus.rs2);
        end else begin
          m_pending <= 1'b1;
          m_left    <= ITER;
          m_next    <= ref_model(bus.funct3, bus.rs1, bus.rs2);
        end
      end
    end
  end

  // Every cycle, every output against the model.
  always @(negedge clk) begin
    assert (!(m_pending && bus.start));
    chk("done",   32'(bus.done),       32'(m_done_now));
    chk("busy",   32'(bus.busy),       32'(m_pending | m_done_now));
    chk("stall",  32'(bus.stall),      32'(~rst & (m_pending | (~m_done_now & bus.start))));
    chk("sel",    32'(bus.mulmux_sel), 32'(m_done_now));
    chk("result", bus.result,          m_res);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int limit, output int t);
    t = 0;
    while (!bus.done && t < limit) begin
      step();
      t++;
    end
    chk("wait_done", 32'(bus.done), 32'd1);
  endtask

  // Issue one op and check latency, stall cycles, select and result against literals.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string nm);
    int t;
    int st;
    bus.start = 1'b1; bus.funct3 = f; bus.rs1 = a; bus.rs2 = b;
    #1;
    st = int'(bus.stall);
    step();
    bus.start = 1'b0;
    t = 1;
    while (!bus.done && t < 60) begin
      st += int'(bus.stall);
      step();
      t++;
    end
    chk({nm, "_lat"},   32'(t),  32'(lat));
    chk({nm, "_stall"}, 32'(st), 32'(lat));
    chk({nm, "_sel"},   32'(bus.mulmux_sel), 32'(MUL_OUT));
    chk({nm, "_res"},   bus.result, exp);
    step();
  endtask

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return DIV_OVF_DIVIDEND;
      3: return 32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t;
    int t1;
    int t2;
    int nd;
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.rs1 = '0; bus.rs2 = '0; bus.flush = 1'b0;
    #1 rst = 1'b1;
    repeat (2) step();
    chk("rst_busy",   32'(bus.busy),       32'd0);
    chk("rst_done",   32'(bus.done),       32'd0);
    chk("rst_stall",  32'(bus.stall),      32'd0);
    chk("rst_result", bus.result,          32'd0);
    chk("rst_sel",    32'(bus.mulmux_sel), 32'(TRUE_ALU_OUT));
    rst = 1'b0;
    step();

    chk("pin_mul",    ref_model(3'd0, 32'd7, 32'hFFFF_FFFD),          32'hFFFF_FFEB);
    chk("pin_mulhu",  ref_model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF),  32'hFFFF_FFFE);
    chk("pin_mulhsu", ref_model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF),  32'hFFFF_FFFF);
    chk("pin_div",    ref_model(3'd4, 32'hFFFF_FFF9, 32'd2),          32'hFFFF_FFFD);
    chk("pin_rem",    ref_model(3'd6, 32'hFFFF_FFF9, 32'd2),          32'hFFFF_FFFF);

    run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem");
    run_op(3'd5, 32'd100,       32'd7,         32'd14,        33, "divu");
    run_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "divu_by0");
    run_op(3'd6, 32'd5,         32'd0,         32'd5,         1,  "rem_by0");
    run_op(3'd4, DIV_OVF_DIVIDEND, 32'hFFFF_FFFF, DIV_OVF_DIVIDEND, 1, "div_ovf");
    run_op(3'd6, DIV_OVF_DIVIDEND, 32'hFFFF_FFFF, 32'd0,       1,  "rem_ovf");

    // Flush in cycle 10 of a DIV: unit idles next cycle and never completes it.
    bus.start = 1'b1; bus.funct3 = 3'd4; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
    step();
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      nd += int'(bus.done);
      step();
    end
    chk("flush_nodone", 32'(nd), 32'd0);
    run_op(3'd0, 32'd6, 32'd9, 32'd54, 33, "mul_after_flush");

    // Asynchronous reset in the middle of a multiply.
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1 = 32'd5; bus.rs2 = 32'd5;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    #1 rst = 1'b1;
    #1;
    chk("arst_busy",   32'(bus.busy),       32'd0);
    chk("arst_done",   32'(bus.done),       32'd0);
    chk("arst_stall",  32'(bus.stall),      32'd0);
    chk("arst_result", bus.result,          32'd0);
    chk("arst_sel",    32'(bus.mulmux_sel), 32'(TRUE_ALU_OUT));
    step();
    rst = 1'b0;
    step();

    // Back-to-back: second op issued in the DONE cycle of the first.
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1 = 32'd3; bus.rs2 = 32'd4;
    step();
    bus.start = 1'b0;
    wait_done(40, t);
    t1 = cyc;
    chk("b2b_res1", bus.result, 32'd12);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.rs1 = 32'd12; bus.rs2 = 32'd5;
    step();
    bus.start = 1'b0;
    wait_done(40, t);
    t2 = cyc;
    chk("b2b_res2", bus.result, 32'd2);
    chk("b2b_gap",  32'(t2 - t1), 32'd33);
    step();

    // Random ops, gaps, back-to-back issue and flushes; checked by the compare process.
    for (int n = 0; n < 70; n++) begin
      bus.start = 1'b1;
      bus.funct3 = 3'($urandom_range(0, 7));
      bus.rs1 = pick_opnd();
      bus.rs2 = pick_opnd();
      step();
      bus.start = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        for (int k = $urandom_range(0, 20); k > 0 && !bus.done; k--) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("rnd_flush_busy", 32'(bus.busy), 32'd0);
      end else begin
        wait_done(40, t);
        if ($urandom_range(0, 2) != 0) begin
          for (int k = $urandom_range(1, 2); k > 0; k--) step();
        end
      end
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
